if_id_stage: RTL and testbench

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/if_id_stage.sv | 96 +++++++++
 tb/tb_if_id_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// IF stage PC register plus the IF/ID pipeline register.
// Holds the fetch PC, captures the fetched word with its PC+4, and
// supports hold and flush (bubble) requests. It also keeps saturating
// stall and flush event counters.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pc_write_i,
  input  logic             if_id_write_i,
  input  logic             branch_i,
  input  logic [31:0]      branch_target_i,
  output logic [31:0]      imem_addr_o,
  input  logic [31:0]      imem_data_i,
  output logic [31:0]      if_id_pc4_o,
  output logic [31:0]      if_id_instr_o,
  output logic             if_id_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  logic [31:0]      r_pc;
  logic [31:0]      r_pc4_p0;
  logic [31:0]      r_instr_p0;
  logic             r_vld_p0;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [31:0]      w_pc4;
  logic             w_take;
  logic             w_stall;

  // A branch is honoured only when both the PC and IF/ID are free to move.
  // Otherwise a stalled branch would be lost or applied twice.
  assign w_pc4   = r_pc + 32'd4;
  assign w_take  = branch_i & pc_write_i & if_id_write_i;
  // A cycle where the PC holds but ID still takes an instruction is a
  // refetch of the same PC, not a pipeline stall, so it is not counted.
  assign w_stall = ~pc_write_i & ~if_id_write_i;

  // PC register: redirect on a taken branch, otherwise step by 4 unless held.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc <= RESET_PC;
    end else if (pc_write_i) begin
      r_pc <= w_take ? branch_target_i : w_pc4;
    end
  end

  // ---- IF -> ID boundary ----
  // IF/ID register: a flush inserts a bubble, a load captures the fetch,
  // and the register holds when the write enable is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_instr_p0 <= NOP_INSTR;
      r_pc4_p0   <= 32'd0;
      r_vld_p0   <= 1'b0;
    end else if (w_take) begin
      r_instr_p0 <= NOP_INSTR;
      r_pc4_p0   <= 32'd0;
      r_vld_p0   <= 1'b0;
    end else if (if_id_write_i) begin
      r_instr_p0 <= imem_data_i;
      r_pc4_p0   <= w_pc4;
      r_vld_p0   <= 1'b1;
    end
  end

  // Event counters: count stall cycles and flushes, saturating at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_take)  r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  assign imem_addr_o   = r_pc;
  assign if_id_pc4_o   = r_pc4_p0;
  assign if_id_instr_o = r_instr_p0;
  assign if_id_valid_o = r_vld_p0;
  assign stall_cnt_o   = r_stall_cnt;
  assign flush_cnt_o   = r_flush_cnt;

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: each driven cycle pushes its expected
// post-edge state, and the entry is popped and compared after the edge.
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int          CW  = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          pc_write_i;
  logic          if_id_write_i;
  logic          branch_i;
  logic [31:0]   branch_target_i;
  logic [31:0]   imem_addr_o;
  logic [31:0]   imem_data_i;
  logic [31:0]   if_id_pc4_o;
  logic [31:0]   if_id_instr_o;
  logic          if_id_valid_o;
  logic [CW-1:0] stall_cnt_o;
  logic [CW-1:0] flush_cnt_o;

  if_id_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .pc_write_i(pc_write_i),
    .if_id_write_i(if_id_write_i), .branch_i(branch_i),
    .branch_target_i(branch_target_i), .imem_addr_o(imem_addr_o),
    .imem_data_i(imem_data_i), .if_id_pc4_o(if_id_pc4_o),
    .if_id_instr_o(if_id_instr_o), .if_id_valid_o(if_id_valid_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign imem_data_i = imem_word(imem_addr_o);

  typedef struct packed {
    logic [31:0]   pc;
    logic [31:0]   pc4;
    logic [31:0]   instr;
    logic          valid;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m.pc = 32'h0; m.pc4 = 32'h0; m.instr = NOP; m.valid = 1'b0;
    m.stall = '0; m.flush = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc"},    imem_addr_o, 32'h0);
    check({tag, "_instr"}, if_id_instr_o, NOP);
    check({tag, "_pc4"},   if_id_pc4_o, 32'h0);
    check({tag, "_vld"},   {31'b0, if_id_valid_o}, 32'h0);
    check({tag, "_stall"}, {28'b0, stall_cnt_o}, 32'h0);
    check({tag, "_flush"}, {28'b0, flush_cnt_o}, 32'h0);
  endtask

  // Drive one cycle, queue its expected result, then compare after the edge.
  task automatic step(input logic pw, input logic iw, input logic br, input logic [31:0] tgt);
    exp_t e;
    exp_t got;
    logic take;
    pc_write_i = pw; if_id_write_i = iw; branch_i = br; branch_target_i = tgt;
    take = br & pw & iw;
    e = m;
    if (pw) e.pc = take ? tgt : m.pc + 32'd4;
    if (take) begin
      e.instr = NOP; e.pc4 = 32'h0; e.valid = 1'b0;
      if (e.flush != 4'hF) e.flush = e.flush + 4'd1;
    end else if (iw) begin
      e.instr = imem_word(m.pc); e.pc4 = m.pc + 32'd4; e.valid = 1'b1;
    end
    if (!pw && !iw && e.stall != 4'hF) e.stall = e.stall + 4'd1;
    q.push_back(e);
    @(posedge clk);
    #1;
    got = q.pop_front();
    check("sb_pc",    imem_addr_o, got.pc);
    check("sb_pc4",   if_id_pc4_o, got.pc4);
    check("sb_instr", if_id_instr_o, got.instr);
    check("sb_vld",   {31'b0, if_id_valid_o}, {31'b0, got.valid});
    check("sb_stall", {28'b0, stall_cnt_o}, {28'b0, got.stall});
    check("sb_flush", {28'b0, flush_cnt_o}, {28'b0, got.flush});
    m = got;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; pc_write_i = 1'b1; if_id_write_i = 1'b1;
    branch_i = 1'b0; branch_target_i = 32'h0;
    model_reset();
    #2;
    check_reset_vals("por");
    @(posedge clk); #1;
    check_reset_vals("por_edge");
    rst_i = 1'b0;

    // Sequential fetch: PC 0 -> 4 -> 8, IF/ID one cycle behind.
    step(1, 1, 0, 32'h0);
    check("seq1_pc4", if_id_pc4_o, 32'h4);
    step(1, 1, 0, 32'h0);
    check("seq2_pc", imem_addr_o, 32'h8);
    check("seq2_instr", if_id_instr_o, imem_word(32'h4));

    // Load-use stall at PC 8, then resume fetching at 8.
    step(0, 0, 0, 32'h0);
    check("ls_pc", imem_addr_o, 32'h8);
    check("ls_pc4", if_id_pc4_o, 32'h8);
    check("ls_stall", {28'b0, stall_cnt_o}, 32'h1);
    step(1, 1, 0, 32'h0);
    check("ls_resume_pc4", if_id_pc4_o, 32'hC);

    // Taken branch from PC 12 to 0x40.
    step(1, 1, 1, 32'h40);
    check("br_pc", imem_addr_o, 32'h40);
    check("br_vld", {31'b0, if_id_valid_o}, 32'h0);
    check("br_flush", {28'b0, flush_cnt_o}, 32'h1);

    // Branch during a stall is ignored.
    step(0, 0, 1, 32'h80);
    check("bst_pc", imem_addr_o, 32'h40);
    check("bst_flush", {28'b0, flush_cnt_o}, 32'h1);

    // PC advances with IF/ID held; the branch is not taken.
    step(1, 0, 1, 32'h80);
    check("pcw_only_pc", imem_addr_o, 32'h44);
    // PC held while IF/ID refetches the current PC; stall count unchanged.
    step(0, 1, 0, 32'h0);
    check("ifw_only_pc4", if_id_pc4_o, 32'h48);
    check("ifw_only_stall", {28'b0, stall_cnt_o}, 32'h2);
    step(1, 1, 0, 32'h0);

    // Async reset between edges, mid-stall with a pending branch.
    pc_write_i = 1'b0; if_id_write_i = 1'b0; branch_i = 1'b1; branch_target_i = 32'h100;
    #2;
    rst_i = 1'b1;
    #1;
    check_reset_vals("arst");
    pc_write_i = 1'b1; if_id_write_i = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("arst_edge");
    rst_i = 1'b0;
    branch_i = 1'b0;
    model_reset();
    q.delete();
    step(1, 1, 0, 32'h0);
    check("arst_first_pc4", if_id_pc4_o, 32'h4);
    check("arst_first_instr", if_id_instr_o, imem_word(32'h0));

    // Stall counter saturation with a 4-bit counter.
    for (int i = 0; i < 18; i++) step(0, 0, 0, 32'h0);
    check("sat_stall", {28'b0, stall_cnt_o}, 32'hF);

    // PC wrap at the top of the address space.
    step(1, 1, 1, 32'hFFFF_FFFC);
    check("wrap_pre_pc", imem_addr_o, 32'hFFFF_FFFC);
    step(1, 1, 0, 32'h0);
    check("wrap_pc", imem_addr_o, 32'h0);
    check("wrap_pc4", if_id_pc4_o, 32'h0);
    check("wrap_vld", {31'b0, if_id_valid_o}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
